// File: rtl/multicycle_controller.sv
// multicycle_controller -- control FSM for the multicycle RISC-V core.
// Sequences the shared-memory datapath through Fetch/Decode/Execute/Writeback
// for lw, sw, R-type, I-type ALU, beq and jal. It produces every datapath
// select and write strobe, includes the ALU decoder, and waits on mem_ready
// in the states that access memory.
// Optional feature: define ILLEGAL_OP_TRAP_EN to lock the FSM in a TRAP state
// on an unknown opcode and raise a sticky illegal_op flag. In the default
// build an unknown opcode is treated as a NOP and illegal_op is tied low.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_JAL     = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
    ,S_TRAP   = 4'd11
`endif
  } state_e;

  state_e state_q, state_d;

  // Raw strobes decoded from state; gated by reset_n before leaving the block.
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       adr_src;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       done_raw;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;

  // Next-state logic: memory states wait for mem_ready, DECODE dispatches on op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
      S_JAL:     state_d = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight and returns to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Moore output decode: selects and raw strobes as a function of state only.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = 2'b00;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        // PC+4 is computed on the ALU and loaded in the same cycle the
        // instruction word arrives, so both strobes follow mem_ready.
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_MEMWR: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        done_raw  = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: ALUOp from the state plus funct fields from the instruction.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format select, decoded straight from the opcode.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write strobes are suppressed for as long as reset is held low.
  assign PCWrite    = reset_n & (pc_update | (branch & zero));
  assign IRWrite    = reset_n & ir_write_raw;
  assign MemWrite   = reset_n & mem_write_raw;
  assign RegWrite   = reset_n & reg_write_raw;
  assign instr_done = reset_n & done_raw;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;

`ifdef ILLEGAL_OP_TRAP_EN
  // TRAP is only left through reset, so the flag is sticky by construction.
  assign illegal_op = (state_q == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (default build, no trap feature).
// Each cycle's control word is compared against hand-derived constants.
module tb_multicycle_controller;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_imm;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  // Control word: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, instr_done}
  logic [11:0] ctl;
  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, instr_done};

  localparam logic [11:0] C_FETCH_R  = 12'b1_0_0_1_0_10_00_10_0;
  localparam logic [11:0] C_FETCH_S  = 12'b0_0_0_0_0_10_00_10_0;
  localparam logic [11:0] C_DECODE   = 12'b0_0_0_0_0_00_01_01_0;
  localparam logic [11:0] C_MEMADR   = 12'b0_0_0_0_0_00_10_01_0;
  localparam logic [11:0] C_MEMREAD  = 12'b0_1_0_0_0_00_00_00_0;
  localparam logic [11:0] C_MEMWB    = 12'b0_0_0_0_1_01_00_00_1;
  localparam logic [11:0] C_MEMWR_S  = 12'b0_1_1_0_0_00_00_00_0;
  localparam logic [11:0] C_MEMWR_A  = 12'b0_1_1_0_0_00_00_00_1;
  localparam logic [11:0] C_EXECR    = 12'b0_0_0_0_0_00_10_00_0;
  localparam logic [11:0] C_EXECI    = 12'b0_0_0_0_0_00_10_01_0;
  localparam logic [11:0] C_ALUWB    = 12'b0_0_0_0_1_00_00_00_1;
  localparam logic [11:0] C_BEQ_T    = 12'b1_0_0_0_0_00_10_00_1;
  localparam logic [11:0] C_BEQ_N    = 12'b0_0_0_0_0_00_10_00_1;
  localparam logic [11:0] C_JAL      = 12'b1_0_0_0_0_00_01_10_0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample on the falling edge, then step past the rising edge.
  task automatic cyc(input string tag, input logic [11:0] exp_ctl, input logic [2:0] exp_alu);
    @(negedge clk);
    check({tag, ".ctl"}, 16'(ctl), 16'(exp_ctl));
    check({tag, ".alu"}, 16'(ALUControl), 16'(exp_alu));
    check({tag, ".imm"}, 16'(ImmSrc), 16'(exp_imm));
    check({tag, ".ill"}, 16'(illegal_op), 16'h0000);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [1:0] imm);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    exp_imm  = imm;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);

    // Reset held: FETCH selects, strobes forced low despite mem_ready=1.
    @(negedge clk);
    check("reset.ctl", 16'(ctl), 16'(C_FETCH_S));
    check("reset.ill", 16'(illegal_op), 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // add
    cyc("add.fetch",  C_FETCH_R, 3'b000);
    cyc("add.decode", C_DECODE,  3'b000);
    cyc("add.execr",  C_EXECR,   3'b000);
    cyc("add.aluwb",  C_ALUWB,   3'b000);

    // sub: op[5] & funct7b5 selects subtract
    set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);
    cyc("sub.fetch",  C_FETCH_R, 3'b000);
    cyc("sub.decode", C_DECODE,  3'b000);
    cyc("sub.execr",  C_EXECR,   3'b001);
    cyc("sub.aluwb",  C_ALUWB,   3'b000);

    // addi with IR[30]=1 must still add (op[5]=0)
    set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);
    cyc("addi.fetch",  C_FETCH_R, 3'b000);
    cyc("addi.decode", C_DECODE,  3'b000);
    cyc("addi.execi",  C_EXECI,   3'b000);
    cyc("addi.aluwb",  C_ALUWB,   3'b000);

    // or (R-type funct3=110)
    set_instr(7'b0110011, 3'b110, 1'b0, 2'b00);
    cyc("or.fetch",  C_FETCH_R, 3'b000);
    cyc("or.decode", C_DECODE,  3'b000);
    cyc("or.execr",  C_EXECR,   3'b011);
    cyc("or.aluwb",  C_ALUWB,   3'b000);

    // lw: mem_ready ignored in MEMADR, two wait cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
    cyc("lw.fetch",  C_FETCH_R, 3'b000);
    cyc("lw.decode", C_DECODE,  3'b000);
    mem_ready = 1'b0;
    cyc("lw.memadr", C_MEMADR,  3'b000);
    cyc("lw.rd0",    C_MEMREAD, 3'b000);
    cyc("lw.rd1",    C_MEMREAD, 3'b000);
    mem_ready = 1'b1;
    cyc("lw.rd2",    C_MEMREAD, 3'b000);
    cyc("lw.memwb",  C_MEMWB,   3'b000);

    // sw: one FETCH stall, then MemWrite held for four MEMWR cycles
    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    mem_ready = 1'b0;
    cyc("sw.fstall", C_FETCH_S, 3'b000);
    mem_ready = 1'b1;
    cyc("sw.fetch",  C_FETCH_R, 3'b000);
    cyc("sw.decode", C_DECODE,  3'b000);
    cyc("sw.memadr", C_MEMADR,  3'b000);
    mem_ready = 1'b0;
    cyc("sw.wr0",    C_MEMWR_S, 3'b000);
    cyc("sw.wr1",    C_MEMWR_S, 3'b000);
    cyc("sw.wr2",    C_MEMWR_S, 3'b000);
    mem_ready = 1'b1;
    cyc("sw.wr3",    C_MEMWR_A, 3'b000);

    // beq taken, then not taken
    set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
    zero = 1'b1;
    cyc("beqt.fetch",  C_FETCH_R, 3'b000);
    cyc("beqt.decode", C_DECODE,  3'b000);
    cyc("beqt.beq",    C_BEQ_T,   3'b001);
    zero = 1'b0;
    cyc("beqn.fetch",  C_FETCH_R, 3'b000);
    cyc("beqn.decode", C_DECODE,  3'b000);
    cyc("beqn.beq",    C_BEQ_N,   3'b001);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
    cyc("jal.fetch",  C_FETCH_R, 3'b000);
    cyc("jal.decode", C_DECODE,  3'b000);
    cyc("jal.jal",    C_JAL,     3'b000);
    cyc("jal.aluwb",  C_ALUWB,   3'b000);

    // unknown opcode: NOP back to FETCH, no instr_done
    set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
    cyc("ill.fetch",  C_FETCH_R, 3'b000);
    cyc("ill.decode", C_DECODE,  3'b000);
    set_instr(7'b0110011, 3'b111, 1'b0, 2'b00);
    cyc("ill.refetch", C_FETCH_R, 3'b000);

    // and, aborted by reset in EXECR: no ALUWB afterwards
    cyc("rst.decode", C_DECODE, 3'b000);
    @(negedge clk);
    check("rst.execr.ctl", 16'(ctl), 16'(C_EXECR));
    check("rst.execr.alu", 16'(ALUControl), 16'(3'b010));
    reset_n = 1'b0;
    #1;
    check("rst.low.ctl", 16'(ctl), 16'(C_FETCH_S));
    @(posedge clk);
    #1;
    check("rst.hold.ctl", 16'(ctl), 16'(C_FETCH_S));
    reset_n = 1'b1;
    cyc("rst.fetch",  C_FETCH_R, 3'b000);
    cyc("rst.decode2", C_DECODE, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
